// File: rtl/button_debouncer.sv
// Pushbutton conditioner: two-flop synchroniser, then a per-channel stability counter
// that accepts a new level only after DEBOUNCE_CYCLES consecutive differing samples.
module button_debouncer #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             press;
    logic             release_q;

    // cnt counts consecutive samples that disagree with stable; any agreement restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stable    <= 1'b0;
        cnt       <= '0;
        press     <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press     <= 1'b0;
        release_q <= 1'b0;
        if (sync2[i] == stable) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          stable    <= sync2[i];
          cnt       <= '0;
          press     <= sync2[i];
          release_q <= ~sync2[i];
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign btn_level[i]   = stable;
    assign btn_press[i]   = press;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Randomised bench for button_debouncer: a window-based reference model predicts the
// outputs after every edge into a queue that a posedge monitor drains and compares.
module tb_button_debouncer;

  localparam int N = 5;
  localparam int D = 4;
  localparam int HIST = 8192;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  always #5 clk = ~clk;

  button_debouncer #(.N_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  logic [3*N-1:0] exp_q[$];
  int             edge_q[$];
  int             checks = 0;
  int             errors = 0;
  bit             mon_en = 1'b0;

  // Reference model: raw value sampled at each edge since reset (edge 1 = first edge
  // after release). A level flips at edge n when the raw samples from edges n-1-D..n-2
  // all differ from the current level; samples before edge 1 count as 0.
  logic [N-1:0] hist[HIST];
  int           n = 0;
  logic [N-1:0] mdl_level = '0;

  function automatic logic [N-1:0] sample(input int e);
    if (e < 1) return '0;
    return hist[e];
  endfunction

  task automatic step(input logic [N-1:0] raw);
    logic [N-1:0] pr;
    logic [N-1:0] rl;
    logic [N-1:0] s;
    bit           all_diff;
    @(negedge clk);
    btn_raw = raw;
    n++;
    hist[n % HIST] = raw;
    pr = '0;
    rl = '0;
    for (int c = 0; c < N; c++) begin
      all_diff = 1'b1;
      for (int k = n - 1 - D; k <= n - 2; k++) begin
        s = sample(k);
        if (s[c] == mdl_level[c]) all_diff = 1'b0;
      end
      if (all_diff) begin
        mdl_level[c] = ~mdl_level[c];
        if (mdl_level[c]) pr[c] = 1'b1;
        else rl[c] = 1'b1;
      end
    end
    exp_q.push_back({mdl_level, pr, rl});
    edge_q.push_back(n);
    mon_en = 1'b1;
  endtask

  task automatic hold(input logic [N-1:0] raw, input int cycles);
    for (int i = 0; i < cycles; i++) step(raw);
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if (btn_level !== '0 || btn_press !== '0 || btn_release !== '0) begin
      errors++;
      $display("FAIL %s: got level=%b press=%b release=%b, expected all zero",
               name, btn_level, btn_press, btn_release);
    end
  endtask

  // Assert reset asynchronously between edges and check the outputs clear at once.
  task automatic assert_reset_mid();
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk_zero("async_reset");
  endtask

  // Keep reset low with raw applied, then release just after an edge.
  task automatic hold_reset(input logic [N-1:0] raw);
    @(negedge clk);
    btn_raw = raw;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_zero("reset_hold");
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    n = 0;
    mdl_level = '0;
    exp_q.delete();
    edge_q.delete();
  endtask

  always @(posedge clk) begin
    logic [3*N-1:0] exp;
    int             e;
    #1;
    if (mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL queue_empty: DUT output with no expectation at time %0t", $time);
      end else begin
        exp = exp_q.pop_front();
        e   = edge_q.pop_front();
        if ({btn_level, btn_press, btn_release} !== exp) begin
          errors++;
          $display("FAIL outputs edge %0d: got level=%b press=%b release=%b, expected level=%b press=%b release=%b",
                   e, btn_level, btn_press, btn_release,
                   exp[3*N-1:2*N], exp[2*N-1:N], exp[N-1:0]);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    int           len;

    // Held buttons through reset: one press on all channels, six edges after release.
    btn_raw = '1;
    hold_reset(5'b11111);
    hold(5'b11111, 10);
    hold(5'b00000, 10);

    // Clean press then release on channel 0.
    hold(5'b00001, 14);
    hold(5'b00000, 14);

    // Bounce on channel 2, then a settled high, then low.
    for (int i = 0; i < 6; i++) hold((i % 2 == 0) ? 5'b00100 : 5'b00000, 2);
    hold(5'b00100, 10);
    hold(5'b00000, 10);

    // Short glitch (D-1 cycles) on channel 3, and an exactly-D-cycle pulse.
    hold(5'b01000, D - 1);
    hold(5'b00000, 10);
    hold(5'b01000, D);
    hold(5'b00000, 12);

    // Simultaneous press on three channels.
    hold(5'b10011, 10);
    hold(5'b00000, 10);

    // Reset while channel 1 is held: level drops with no release, then re-accepted.
    hold(5'b00010, 10);
    assert_reset_mid();
    hold_reset(5'b00010);
    hold(5'b00010, 10);

    // Random runs of lengths around D, with occasional mid-run resets.
    for (int seg = 0; seg < 120; seg++) begin
      r   = N'($urandom_range(0, (1 << N) - 1));
      len = $urandom_range(1, 2 * D + 1);
      hold(r, len);
      if ($urandom_range(0, 39) == 0) begin
        assert_reset_mid();
        hold_reset(N'($urandom_range(0, (1 << N) - 1)));
      end
    end
    hold(5'b00000, 10);

    @(posedge clk);
    #2;
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
